// File: rtl/axi4_slave_mem_if.sv
// AXI4 slave memory bus: AW/W/B and AR/R channel signals (IDs, size and burst type not carried).
interface axi4_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [7:0]                awlen;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wlast;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [7:0]                arlen;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rlast;

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arlen, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
  );

  modport master (
    output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arlen, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: DEPTH x DATA_WIDTH RAM, independent read/write FSMs,
// one outstanding INCR burst per direction, per-beat range checking.
// Optional macro AXI_SLV_BACKPRESSURE_EN: LFSR-driven ready gating and R bubbles.
module axi4_slave_mem #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           MEM_AW     = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic             ap_clk,
  input logic             areset,
  axi4_slave_mem_if.slave s_axi
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFFS  = $clog2(BYTES);
  localparam int unsigned DEPTH = 2 ** MEM_AW;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            w_state;
  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [7:0]            w_len;
  logic [7:0]            w_beat;
  logic                  w_low;
  logic                  w_err;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic                  r_low;
  logic                  r_oor_q;
  logic [DATA_WIDTH-1:0] rd_q;

  logic aw_gate, w_gate, ar_gate, r_show;
  logic aw_hs, w_hs, ar_hs, r_hs;
  logic w_oor, r_oor, rvalid_i, rlast_i, rd_en;

`ifdef AXI_SLV_BACKPRESSURE_EN
  logic [15:0] lfsr;
  logic        r_shown;

  // Free-running LFSR supplying pseudo-random stall decisions.
  always_ff @(posedge ap_clk) begin
    if (areset) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Remember that the current beat was presented so rvalid cannot drop before acceptance.
  always_ff @(posedge ap_clk) begin
    if (areset) r_shown <= 1'b0;
    else        r_shown <= rvalid_i && !s_axi.rready;
  end

  assign aw_gate = lfsr[0];
  assign w_gate  = lfsr[1];
  assign ar_gate = lfsr[2];
  assign r_show  = r_shown || lfsr[3];
`else
  assign aw_gate = 1'b1;
  assign w_gate  = 1'b1;
  assign ar_gate = 1'b1;
  assign r_show  = 1'b1;
`endif

  assign aw_hs    = !areset && (w_state == W_IDLE) && aw_gate && s_axi.awvalid;
  assign w_hs     = !areset && (w_state == W_DATA) && w_gate && s_axi.wvalid;
  assign ar_hs    = !areset && (r_state == R_IDLE) && ar_gate && s_axi.arvalid;
  assign rvalid_i = !areset && (r_state == R_DATA) && r_show;
  assign r_hs     = rvalid_i && s_axi.rready;
  assign rlast_i  = (r_beat == r_len);
  assign w_oor    = w_low || (|w_ptr[ADDR_WIDTH-1:MEM_AW]);
  assign r_oor    = r_low || (|r_ptr[ADDR_WIDTH-1:MEM_AW]);
  // The word for the next beat is fetched in the same cycle the current one is accepted.
  assign rd_en    = !areset && ((r_state == R_FETCH) || (r_hs && !rlast_i));

  assign s_axi.awready = !areset && (w_state == W_IDLE) && aw_gate;
  assign s_axi.wready  = !areset && (w_state == W_DATA) && w_gate;
  assign s_axi.bvalid  = !areset && (w_state == W_RESP);
  assign s_axi.bresp   = (s_axi.bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.arready = !areset && (r_state == R_IDLE) && ar_gate;
  assign s_axi.rvalid  = rvalid_i;
  assign s_axi.rlast   = rvalid_i && rlast_i;
  assign s_axi.rdata   = (!areset && (r_state == R_DATA) && !r_oor_q) ? rd_q : '0;
  assign s_axi.rresp   = (!areset && (r_state == R_DATA) && r_oor_q) ? RESP_SLVERR : RESP_OKAY;

  // RAM: byte-masked write, registered read-first port.
  always_ff @(posedge ap_clk) begin
    if (w_hs && !w_oor) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (s_axi.wstrb[b]) mem[w_ptr[MEM_AW-1:0]][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
    if (rd_en) begin
      rd_q    <= mem[r_ptr[MEM_AW-1:0]];
      r_oor_q <= r_oor;
    end
  end

  // Write FSM: address latch, data beats counted against awlen, then B response.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      w_state <= W_IDLE;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          w_ptr   <= (s_axi.awaddr - BASE_ADDR) >> OFFS;
          w_low   <= s_axi.awaddr < BASE_ADDR;
          w_len   <= s_axi.awlen;
          w_beat  <= '0;
          w_err   <= 1'b0;
          w_state <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          w_ptr  <= w_ptr + 1'b1;
          w_beat <= w_beat + 8'd1;
          w_err  <= w_err || w_oor || (s_axi.wlast != (w_beat == w_len));
          if (w_beat == w_len) w_state <= W_RESP;
        end
        W_RESP: if (s_axi.bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: address latch, one fetch cycle, then one beat per accepted cycle.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_state <= R_IDLE;
    end else begin
      case (r_state)
        R_IDLE: if (ar_hs) begin
          r_ptr   <= (s_axi.araddr - BASE_ADDR) >> OFFS;
          r_low   <= s_axi.araddr < BASE_ADDR;
          r_len   <= s_axi.arlen;
          r_beat  <= '0;
          r_state <= R_FETCH;
        end
        R_FETCH: begin
          r_ptr   <= r_ptr + 1'b1;
          r_state <= R_DATA;
        end
        R_DATA: if (r_hs) begin
          if (rlast_i) begin
            r_state <= R_IDLE;
          end else begin
            r_ptr  <= r_ptr + 1'b1;
            r_beat <= r_beat + 8'd1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed self-checking bench for axi4_slave_mem (DEPTH=16, 32-bit data).
module tb_axi4_slave_mem;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic ap_clk;
  logic areset;
  int unsigned cyc = 0;
  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  logic [31:0] exp_d [256];
  logic [1:0]  exp_r [256];

  axi4_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_slave_mem #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_AW(4),
    .BASE_ADDR(BASE)
  ) dut (
    .ap_clk(ap_clk),
    .areset(areset),
    .s_axi(bus.slave)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] l);
    int unsigned n = 0;
    bus.awvalid = 1'b1; bus.awaddr = a; bus.awlen = l;
    while (!bus.awready && n < 100) begin @(posedge ap_clk); #1; n++; end
    if (n >= 100) check("aw_timeout", bus.awready, 1);
    @(posedge ap_clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic last);
    int unsigned n = 0;
    bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s; bus.wlast = last;
    while (!bus.wready && n < 100) begin @(posedge ap_clk); #1; n++; end
    if (n >= 100) check("w_timeout", bus.wready, 1);
    @(posedge ap_clk); #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic b_check(input string tag, input logic [1:0] exp);
    int unsigned n = 0;
    bus.bready = 1'b1;
    while (!bus.bvalid && n < 100) begin @(posedge ap_clk); #1; n++; end
    if (n >= 100) check({tag, "_timeout"}, bus.bvalid, 1);
    else          check(tag, bus.bresp, exp);
    @(posedge ap_clk); #1;
  endtask

  // Read burst checked against exp_d/exp_r; stall applies the rready pattern 1,0,0,1.
  task automatic r_burst(input string tag, input logic [31:0] a, input logic [7:0] l, input logic stall);
    int unsigned i = 0;
    int unsigned c = 0;
    int unsigned n = 0;
    bus.arvalid = 1'b1; bus.araddr = a; bus.arlen = l;
    while (!bus.arready && n < 100) begin @(posedge ap_clk); #1; n++; end
    if (n >= 100) check({tag, "_ar_timeout"}, bus.arready, 1);
    @(posedge ap_clk); #1;
    bus.arvalid = 1'b0;
    check({tag, "_lat1_rvalid"}, bus.rvalid, 0);
    @(posedge ap_clk); #1;
    check({tag, "_lat2_rvalid"}, bus.rvalid, 1);
    while (i <= l && c < 2000) begin
      bus.rready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (bus.rvalid) begin
        check({tag, "_rdata"}, bus.rdata, exp_d[i]);
        check({tag, "_rresp"}, bus.rresp, exp_r[i]);
        check({tag, "_rlast"}, bus.rlast, (i == l));
        if (bus.rready) i++;
      end
      @(posedge ap_clk); #1;
      c++;
    end
    if (i <= l) check({tag, "_r_timeout"}, i, l + 1);
    bus.rready = 1'b0;
    check({tag, "_done_rvalid"}, bus.rvalid, 0);
  endtask

  initial begin
    logic early;
    int unsigned c0;
    areset = 1'b1;
    bus.awvalid = 0; bus.awaddr = '0; bus.awlen = '0;
    bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0;
    bus.bready = 1'b1;
    bus.arvalid = 0; bus.araddr = '0; bus.arlen = '0; bus.rready = 0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_awready", bus.awready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_bvalid",  bus.bvalid, 0);
    check("rst_rvalid",  bus.rvalid, 0);
    areset = 1'b0;
    #1;
    check("idle_awready", bus.awready, 1);
    check("idle_arready", bus.arready, 1);
    check("idle_wready",  bus.wready, 0);
    @(posedge ap_clk); #1;

    // 1: four-beat write to words 4..7
    aw_send(BASE + 32'h10, 8'd3);
    c0 = cyc;
    for (int i = 0; i < 4; i++) w_send(32'(32'h11 * (i + 1)), 4'hF, i == 3);
    check("t1_beat_cycles", cyc - c0, 4);
    check("t1_bvalid", bus.bvalid, 1);
    b_check("t1_bresp", OKAY);

    // 2: back-to-back readback
    for (int i = 0; i < 4; i++) begin exp_d[i] = 32'(32'h11 * (i + 1)); exp_r[i] = OKAY; end
    r_burst("t2", BASE + 32'h10, 8'd3, 1'b0);

    // 3: same read under rready stalls
    r_burst("t3", BASE + 32'h10, 8'd3, 1'b1);

    // 4: partial strobe over a full word
    aw_send(BASE + 32'h14, 8'd0);
    w_send(32'h2222_2222, 4'hF, 1'b1);
    b_check("t4_bresp_full", OKAY);
    aw_send(BASE + 32'h14, 8'd0);
    w_send(32'hAABB_CCDD, 4'b0101, 1'b1);
    b_check("t4_bresp_strb", OKAY);
    exp_d[0] = 32'h22BB_22DD; exp_r[0] = OKAY;
    r_burst("t4", BASE + 32'h14, 8'd0, 1'b0);

    // 5: burst past the top of memory, then wlast mismatch
    aw_send(BASE, 8'd1);
    w_send(32'hA0, 4'hF, 1'b0);
    w_send(32'hA1, 4'hF, 1'b1);
    b_check("t5_low_bresp", OKAY);
    aw_send(BASE + 32'd56, 8'd3);
    for (int i = 0; i < 4; i++) w_send(32'(32'hE0 + i), 4'hF, i == 3);
    b_check("t5_top_bresp", SLVERR);
    exp_d[0] = 32'hE0; exp_d[1] = 32'hE1; exp_d[2] = '0; exp_d[3] = '0;
    exp_r[0] = OKAY; exp_r[1] = OKAY; exp_r[2] = SLVERR; exp_r[3] = SLVERR;
    r_burst("t5_top", BASE + 32'd56, 8'd3, 1'b0);
    exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_r[0] = OKAY; exp_r[1] = OKAY;
    r_burst("t5_nowrap", BASE, 8'd1, 1'b0);
    aw_send(BASE + 32'h20, 8'd1);
    w_send(32'h88, 4'hF, 1'b1);
    check("t5_wl_bvalid_mid", bus.bvalid, 0);
    check("t5_wl_wready_mid", bus.wready, 1);
    w_send(32'h99, 4'hF, 1'b0);
    b_check("t5_wl_bresp", SLVERR);
    exp_d[0] = 32'h88; exp_d[1] = 32'h99;
    r_burst("t5_wl", BASE + 32'h20, 8'd1, 1'b0);

    // 6: reset during beat 2 of a read
    bus.arvalid = 1'b1; bus.araddr = BASE + 32'h10; bus.arlen = 8'd3;
    check("t6_arready", bus.arready, 1);
    @(posedge ap_clk); #1;
    bus.arvalid = 1'b0;
    @(posedge ap_clk); #1;
    bus.rready = 1'b1;
    check("t6_beat0", bus.rdata, 32'h11);
    @(posedge ap_clk); #1;
    check("t6_beat1", bus.rdata, 32'h22BB_22DD);
    @(posedge ap_clk); #1;
    check("t6_beat2", bus.rdata, 32'h33);
    areset = 1'b1;
    #1;
    check("t6_rst_rvalid", bus.rvalid, 0);
    @(posedge ap_clk); #1;
    areset = 1'b0;
    #1;
    check("t6_post_rvalid", bus.rvalid, 0);
    @(posedge ap_clk); #1;
    check("t6_idle_rvalid", bus.rvalid, 0);
    bus.rready = 1'b0;
    exp_d[0] = 32'h44; exp_r[0] = OKAY;
    r_burst("t6_single", BASE + 32'h1C, 8'd0, 1'b0);

    // 7: address below BASE
    exp_d[0] = '0; exp_r[0] = SLVERR;
    r_burst("t7_below", BASE - 32'd4, 8'd0, 1'b0);

    // 8: 256-beat write, only the first 16 land
    aw_send(BASE, 8'd255);
    early = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w_send(32'(i), 4'hF, i == 255);
      if (i < 255 && bus.bvalid) early = 1'b1;
    end
    check("t8_early_bvalid", early, 0);
    check("t8_bvalid", bus.bvalid, 1);
    b_check("t8_bresp", SLVERR);
    for (int i = 0; i < 16; i++) begin exp_d[i] = 32'(i); exp_r[i] = OKAY; end
    r_burst("t8_read", BASE, 8'd15, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
